// File: rtl/exe_unit_pkg.sv
// Shared definitions for the execute stage: opcodes, multiplier states,
// reset vector and reset polarity.
package exe_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_MUL  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  // Reset vector, truncated to XLEN at the point of use.
  localparam logic [63:0] CPU_RESET_ADDR = 64'h0000_0000_0000_0000;

  // Reset is asserted low.
  localparam logic RST_ENABLE = 1'b0;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, result
// held in DONE until the consumer takes it.
module exe_mul_iter
  import exe_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            take_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0] mult_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned CW = $clog2(XLEN);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mult_q, mult_d;
  logic [CW-1:0]   count_q, count_d;

  // State and datapath registers; reset abandons any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      state_q <= MUL_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      count_q <= count_d;
    end
  end

  // Next-state and shift-add step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    count_d = count_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d = MUL_RUN;
          mcand_d = mcand_i;
          mult_d  = mult_i;
          acc_d   = '0;
          count_d = '0;
        end
      end
      MUL_RUN: begin
        if (mult_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (take_i) begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign busy_o    = (state_q != MUL_IDLE);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/exe_unit.sv
// Execute stage: integer ALU with registered result, valid/ready handshake
// on both sides, optional iterative multiplier.
module exe_unit
  import exe_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned OPW    = 4,
  parameter int unsigned MUL_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OPW-1:0]  alu_op_i,
  input  logic            alu_src_i,
  input  logic [XLEN-1:0] reg_data_1_i,
  input  logic [XLEN-1:0] reg_data_2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [4:0]      rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] w_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  // Opcode compared at >= 4 bits so any extra upper bits make the op illegal.
  localparam int unsigned OPX = (OPW > 4) ? OPW : 4;
  localparam bit          HAS_MUL = (MUL_EN != 0);

  logic [OPX-1:0]  op_x;
  logic [XLEN-1:0] op1, op2, alu_res;
  logic [SHW-1:0]  shamt;
  logic            out_free, accept, op_is_mul, mul_start;
  logic            mul_busy, mul_done;
  logic [XLEN-1:0] mul_prod;
  logic [XLEN-1:0] mul_pc_q;
  logic [4:0]      mul_rd_q;

  assign op_x  = OPX'(alu_op_i);
  assign op1   = reg_data_1_i;
  assign op2   = alu_src_i ? imm_i : reg_data_2_i;
  assign shamt = op2[SHW-1:0];

  assign op_is_mul  = HAS_MUL && (op_x == OPX'(ALU_MUL));
  assign out_free   = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~mul_busy & out_free;
  assign accept     = in_valid_i & in_ready_o;
  assign mul_start  = accept & op_is_mul;
  assign busy_o     = mul_busy;

  // Single-cycle ALU; MUL and unused codes fall through to zero.
  always_comb begin
    alu_res = '0;
    case (op_x)
      OPX'(ALU_ADD):  alu_res = op1 + op2;
      OPX'(ALU_SUB):  alu_res = op1 - op2;
      OPX'(ALU_AND):  alu_res = op1 & op2;
      OPX'(ALU_OR):   alu_res = op1 | op2;
      OPX'(ALU_XOR):  alu_res = op1 ^ op2;
      OPX'(ALU_SLL):  alu_res = op1 << shamt;
      OPX'(ALU_SRL):  alu_res = op1 >> shamt;
      OPX'(ALU_SRA):  alu_res = $unsigned($signed(op1) >>> shamt);
      OPX'(ALU_SLT):  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OPX'(ALU_SLTU): alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      default:        alu_res = '0;
    endcase
  end

  generate
    if (HAS_MUL) begin : g_mul
      exe_mul_iter #(
        .XLEN(XLEN)
      ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .take_i    (out_free),
        .mcand_i   (op1),
        .mult_i    (op2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // pc/rd of a multiply ride alongside it until the product is written out.
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      mul_pc_q <= '0;
      mul_rd_q <= '0;
    end else if (mul_start) begin
      mul_pc_q <= pc_i;
      mul_rd_q <= rd_i;
    end
  end

  // Output register: load on ALU accept or finished multiply, else drain on ready.
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      out_valid_o <= 1'b0;
      w_data_o    <= '0;
      pc_o        <= XLEN'(CPU_RESET_ADDR);
      rd_o        <= '0;
    end else if (accept && !op_is_mul) begin
      out_valid_o <= 1'b1;
      w_data_o    <= alu_res;
      pc_o        <= pc_i;
      rd_o        <= rd_i;
    end else if (mul_done && out_free) begin
      out_valid_o <= 1'b1;
      w_data_o    <= mul_prod;
      pc_o        <= mul_pc_q;
      rd_o        <= mul_rd_q;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_unit.sv
// Bench for exe_unit: directed cases plus randomized traffic against an
// in-order result queue computed from plain arithmetic.
module tb_exe_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MUL_TMO  = XLEN + 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid, in_ready, in_ready2;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [31:0] rd1, rd2, imm, pc;
  logic [4:0]  rd;
  logic        out_valid, out_ready, busy;
  logic [31:0] w_data, pc_o;
  logic [4:0]  rd_o;
  logic        out_valid2, busy2;
  logic [31:0] w_data2, pc_o2;
  logic [4:0]  rd_o2;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          is_mul;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mul_wait = 0;
  bit   last_acc;
  bit   hold;

  always #5 clk = ~clk;

  exe_unit #(.XLEN(XLEN), .OPW(4), .MUL_EN(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_op_i(alu_op), .alu_src_i(alu_src), .reg_data_1_i(rd1), .reg_data_2_i(rd2),
    .imm_i(imm), .pc_i(pc), .rd_i(rd), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .w_data_o(w_data), .pc_o(pc_o), .rd_o(rd_o), .busy_o(busy)
  );

  exe_unit #(.XLEN(XLEN), .OPW(4), .MUL_EN(0)) dut_nomul (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .alu_op_i(alu_op), .alu_src_i(alu_src), .reg_data_1_i(rd1), .reg_data_2_i(rd2),
    .imm_i(imm), .pc_i(pc), .rd_i(rd), .out_valid_o(out_valid2), .out_ready_i(out_ready),
    .w_data_o(w_data2), .pc_o(pc_o2), .rd_o(rd_o2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result of one operation, from the arithmetic definition of each opcode.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] prod;
    sh = b % 32;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'h8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: begin
        prod = {32'h0, a} * {32'h0, b};
        return prod[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input logic [3:0] op, input logic src, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im);
    in_valid = 1'b1;
    alu_op   = op;
    alu_src  = src;
    rd1      = a;
    rd2      = b;
    imm      = im;
    pc       = $urandom & 32'hFFFF_FFFC;
    rd       = 5'($urandom);
  endtask

  // Compare registered outputs with the head of the expected-result queue.
  task automatic check_outputs();
    if (q.size() == 0) begin
      check("out_valid_idle", 32'(out_valid), 32'd0);
    end else if (!q[0].is_mul || out_valid) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("w_data", w_data, q[0].data);
      check("pc_o", pc_o, q[0].pc);
      check("rd_o", 32'(rd_o), 32'(q[0].rd));
      check("busy_with_valid", 32'(busy), 32'd0);
    end else begin
      check("busy_mul", 32'(busy), 32'd1);
      check("in_ready_mul", 32'(in_ready), 32'd0);
      mul_wait++;
      if (mul_wait > MUL_TMO) begin
        check("mul_timeout", 32'(out_valid), 32'd1);
        void'(q.pop_front());
        mul_wait = 0;
      end
    end
  endtask

  // One clock: record handshakes against the model, then check after the edge.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (rst_i) begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        mul_wait = 0;
      end
      if (in_valid && in_ready) begin
        e.data   = ref_alu(alu_op, rd1, alu_src ? imm : rd2);
        e.pc     = pc;
        e.rd     = rd;
        e.is_mul = (alu_op == 4'hA);
        if (q.size() == 0) mul_wait = 0;
        q.push_back(e);
        last_acc = 1'b1;
      end
    end else begin
      q.delete();
      mul_wait = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_result();
    for (int k = 0; k < 60 && !out_valid; k++) tick();
  endtask

  initial begin
    rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; alu_src = 1'b0; rd1 = '0; rd2 = '0; imm = '0; pc = '0; rd = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    check("rst_pc", pc_o, RESET_PC);
    rst_i = 1'b1;
    @(negedge clk);

    // ADD 7+5
    set_op(4'h0, 1'b0, 32'd7, 32'd5, 32'd99);
    tick();
    in_valid = 1'b0;
    check("t1_add", w_data, 32'd12);
    check("t1_valid", 32'(out_valid), 32'd1);
    tick();

    // back-to-back SUB, SRA, SLTU
    set_op(4'h1, 1'b0, 32'd0, 32'd1, 32'd0);
    tick();
    check("t2_sub", w_data, 32'hFFFF_FFFF);
    set_op(4'h7, 1'b1, 32'h8000_0000, 32'd0, 32'd4);
    tick();
    check("t2_sra", w_data, 32'hF800_0000);
    set_op(4'h9, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    check("t2_sltu", w_data, 32'd1);
    in_valid = 1'b0;
    tick();

    // backpressure
    out_ready = 1'b0;
    set_op(4'h3, 1'b1, 32'h0000_00F0, 32'h0, 32'h0000_000F);
    tick();
    set_op(4'h0, 1'b0, 32'd3, 32'd4, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold", w_data, 32'hFF);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("t3_next", w_data, 32'd7);
    in_valid = 1'b0;
    tick();

    // multiplies
    set_op(4'hA, 1'b0, 32'd1234, 32'd5678, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    wait_result();
    check("t4_mul", w_data, 32'd7006652);
    tick();
    set_op(4'hA, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd2);
    tick();
    in_valid = 1'b0;
    wait_result();
    check("t4_mul_wrap", w_data, 32'hFFFF_FFFE);
    tick();

    // reset mid-multiply
    set_op(4'hA, 1'b0, 32'd99, 32'd77, 32'd0);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_i = 1'b0;
    tick();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_pc", pc_o, RESET_PC);
    rst_i = 1'b1;
    repeat (40) tick();

    // illegal op, and MUL on the build without a multiplier
    set_op(4'hC, 1'b0, 32'h1234, 32'h5678, 32'd0);
    tick();
    check("t6_illegal", w_data, 32'd0);
    check("t6_valid", 32'(out_valid), 32'd1);
    set_op(4'hA, 1'b0, 32'd3, 32'd4, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t6_nomul_valid", 32'(out_valid2), 32'd1);
    check("t6_nomul_data", w_data2, 32'd0);
    check("t6_nomul_busy", 32'(busy2), 32'd0);
    wait_result();
    tick();

    // randomized traffic
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hA && ($urandom % 3) != 0) op = 4'($urandom_range(0, 9));
        set_op(op, 1'($urandom), pick(), pick(), pick());
        in_valid = (($urandom % 4) != 0);
      end
      out_ready = (($urandom % 4) != 0);
      tick();
      hold = in_valid && !last_acc;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (50) tick();
    check("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
